// File: rtl/axi_read_slave_mem_if.sv
// rtl/axi_read_slave_mem_if.sv - AXI4 read address and read data channel bundle
interface axi_read_slave_mem_if #(
  parameter int ID_W   = 7,
  parameter int DATA_W = 256
);
  logic [ID_W-1:0]   arid;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_read_slave_mem.sv
// rtl/axi_read_slave_mem.sv - AXI4 read responder over a preloadable word memory
// Optional AXI_RD_ERR_CHECK_EN: SLVERR for arsize above the word size or illegal WRAP lengths.
module axi_read_slave_mem #(
  parameter int  DATA_W    = 256,
  parameter int  ID_W      = 7,
  parameter int  MEM_DEPTH = 16,
  localparam int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  axi_read_slave_mem_if.slave axi,
  input  logic                i_wr_en,
  input  logic [IDX_W-1:0]    i_wr_idx,
  input  logic [DATA_W-1:0]   i_wr_data
);
  localparam int BYTE_W = $clog2(DATA_W / 8);

  typedef enum logic {IDLE, DATA} state_e;

  state_e            state_q, state_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [31:0]       addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  logic              wrap_len_ok;
  logic              ar_err;
  logic              load_en;
  logic              load_err;
  logic [31:0]       load_addr;

  assign wrap_len_ok = axi.arlen inside {8'd1, 8'd3, 8'd7, 8'd15};

`ifdef AXI_RD_ERR_CHECK_EN
  assign ar_err = (axi.arsize > 3'(BYTE_W)) || ((axi.arburst == 2'b10) && !wrap_len_ok);
`else
  assign ar_err = 1'b0;
`endif

  // WRAP keeps the incremented offset inside the (len+1)<<size aligned window
  function automatic logic [31:0] step_addr(input logic [31:0] a, input logic [2:0] s,
                                            input logic [1:0] b, input logic [7:0] len);
    logic [31:0] inc, nxt, wb, res;
    inc = 32'd1 << s;
    nxt = (a & ~(inc - 32'd1)) + inc;
    wb  = ({24'd0, len} + 32'd1) << s;
    case (b)
      2'b00:   res = a;
      2'b10:   res = (a & ~(wb - 32'd1)) | (nxt & (wb - 32'd1));
      default: res = nxt;
    endcase
    return res;
  endfunction

  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    size_d    = size_q;
    burst_d   = burst_q;
    err_d     = err_q;
    load_en   = 1'b0;
    load_addr = addr_q;
    load_err  = err_q;
    case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        if (axi.arvalid && arready_q) begin
          addr_d    = axi.araddr;
          len_d     = axi.arlen;
          size_d    = (axi.arsize > 3'(BYTE_W)) ? 3'(BYTE_W) : axi.arsize;
          burst_d   = ((axi.arburst == 2'b11) || ((axi.arburst == 2'b10) && !wrap_len_ok))
                      ? 2'b01 : axi.arburst;
          err_d     = ar_err;
          cnt_d     = 8'd0;
          rid_d     = axi.arid;
          rvalid_d  = 1'b1;
          rlast_d   = (axi.arlen == 8'd0);
          arready_d = 1'b0;
          state_d   = DATA;
          load_en   = 1'b1;
          load_addr = axi.araddr;
          load_err  = ar_err;
        end
      end
      DATA: begin
        if (rvalid_q && axi.rready) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            state_d   = IDLE;
          end else begin
            load_addr = step_addr(addr_q, size_q, burst_q, len_q);
            addr_d    = load_addr;
            cnt_d     = cnt_q + 8'd1;
            rlast_d   = ((cnt_q + 8'd1) == len_q);
            load_en   = 1'b1;
          end
        end
      end
    endcase
    // Out-of-range words return zero with DECERR, overriding any SLVERR
    if (load_en) begin
      if ((load_addr >> BYTE_W) >= 32'(MEM_DEPTH)) begin
        rdata_d = '0;
        rresp_d = 2'b11;
      end else begin
        rdata_d = mem_q[load_addr[BYTE_W +: IDX_W]];
        rresp_d = load_err ? 2'b10 : 2'b00;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem_q[i_wr_idx] <= i_wr_data;
  end

  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rlast   = rlast_q;
  assign axi.rid     = rid_q;
  assign axi.rresp   = rresp_q;
  assign axi.rdata   = rdata_q;
endmodule

// File: tb/tb_axi_read_slave_mem.sv
// tb/tb_axi_read_slave_mem.sv - self-checking bench for axi_read_slave_mem
module tb_axi_read_slave_mem;
  localparam int DATA_W    = 256;
  localparam int ID_W      = 7;
  localparam int MEM_DEPTH = 16;

  logic         i_clk     = 1'b0;
  logic         i_reset   = 1'b1;
  logic         i_wr_en   = 1'b0;
  logic [3:0]   i_wr_idx  = '0;
  logic [255:0] i_wr_data = '0;

  axi_read_slave_mem_if #(.ID_W(ID_W), .DATA_W(DATA_W)) axi ();

  axi_read_slave_mem #(.DATA_W(DATA_W), .ID_W(ID_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .axi      (axi),
    .i_wr_en  (i_wr_en),
    .i_wr_idx (i_wr_idx),
    .i_wr_data(i_wr_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [6:0]   id;
    logic [255:0] data;
    logic [1:0]   resp;
    logic         last;
    int           cyc;
  } beat_t;

  beat_t        exp_q[$];
  beat_t        got_q[$];
  logic [255:0] mdl_mem [16];
  int           n_vec   = 0;
  int           n_err   = 0;
  int           cyc     = 0;
  int           ar_cyc  = 0;
  bit           chk_en  = 1'b0;
  bit           rst_prev = 1'b1;
  int           rr_mode = 0;
  int           rr_ph   = 0;

  function automatic logic [255:0] fill(input logic [7:0] b);
    return {32{b}};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected beats straight from the AXI address formulas
  task automatic push_burst(input logic [6:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] sz, input logic [1:0] bt);
    int          s;
    logic [31:0] nb, start, wb, lo, ad;
    logic [1:0]  b;
    bit          err;
    beat_t       e;
    s     = (sz > 3'd5) ? 5 : int'(sz);
    nb    = 32'd1 << s;
    b     = bt;
    err   = 1'b0;
`ifdef AXI_RD_ERR_CHECK_EN
    if (sz > 3'd5) err = 1'b1;
    if (bt == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) err = 1'b1;
`endif
    if (b == 2'b11) b = 2'b01;
    if (b == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) b = 2'b01;
    start = a - (a % nb);
    wb    = (32'(len) + 32'd1) * nb;
    lo    = start - (start % wb);
    for (int i = 0; i <= int'(len); i++) begin
      if (i == 0 || b == 2'b00) ad = a;
      else if (b == 2'b10) ad = lo + ((start - lo + 32'(i) * nb) % wb);
      else ad = start + 32'(i) * nb;
      e.id   = id;
      e.last = (i == int'(len));
      e.cyc  = 0;
      if ((ad >> 5) >= 32'(MEM_DEPTH)) begin
        e.data = '0;
        e.resp = 2'b11;
      end else begin
        e.data = mdl_mem[ad[8:5]];
        e.resp = err ? 2'b10 : 2'b00;
      end
      exp_q.push_back(e);
    end
  endtask

  initial begin
    beat_t g;
    forever begin
      @(negedge i_clk);
      cyc++;
      if (chk_en) begin
        check("arready", axi.arready, (exp_q.size() == 0 && !rst_prev));
        check("rvalid", axi.rvalid, (exp_q.size() != 0));
        if (rst_prev) begin
          check("rst_rid", axi.rid, 0);
          check("rst_rdata", axi.rdata, 0);
          check("rst_rresp", axi.rresp, 0);
          check("rst_rlast", axi.rlast, 0);
        end else if (axi.rvalid && exp_q.size() != 0) begin
          check("rid", axi.rid, exp_q[0].id);
          check("rdata", axi.rdata, exp_q[0].data);
          check("rresp", axi.rresp, exp_q[0].resp);
          check("rlast", axi.rlast, exp_q[0].last);
          if (axi.rready) begin
            g.id = axi.rid; g.data = axi.rdata; g.resp = axi.rresp;
            g.last = axi.rlast; g.cyc = cyc;
            got_q.push_back(g);
            void'(exp_q.pop_front());
          end
        end else if (!axi.rvalid) begin
          check("rlast_idle", axi.rlast, 0);
        end
        if (i_reset) exp_q.delete();
        else if (axi.arvalid && axi.arready) begin
          ar_cyc = cyc;
          push_burst(axi.arid, axi.araddr, axi.arlen, axi.arsize, axi.arburst);
        end
      end
      rst_prev = i_reset;
    end
  end

  initial begin
    axi.rready = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      if (rr_mode == 0) axi.rready = 1'b1;
      else begin
        axi.rready = (rr_ph % 4 == 0) || (rr_ph % 4 == 3);
        rr_ph++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic preload(input int idx, input logic [255:0] d);
    @(posedge i_clk); #1;
    i_wr_en = 1'b1; i_wr_idx = 4'(idx); i_wr_data = d;
    @(posedge i_clk);
    mdl_mem[idx] = d;
    #1 i_wr_en = 1'b0;
  endtask

  task automatic do_ar(input logic [6:0] id, input logic [31:0] a, input logic [7:0] len,
                       input logic [2:0] sz, input logic [1:0] b);
    int t;
    t = 0;
    @(posedge i_clk); #1;
    axi.arid = id; axi.araddr = a; axi.arlen = len; axi.arsize = sz; axi.arburst = b;
    axi.arvalid = 1'b1;
    do begin
      @(negedge i_clk); #1;
      t++;
    end while (!axi.arready && t < 50);
    check("ar_accept", axi.arready, 1);
    @(posedge i_clk); #1;
    axi.arvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge i_clk); #1;
      t++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic run(input logic [6:0] id, input logic [31:0] a, input logic [7:0] len,
                     input logic [2:0] sz, input logic [1:0] b);
    got_q.delete();
    do_ar(id, a, len, sz, b);
    wait_drain();
  endtask

  task automatic lit(input string nm, input int k, input logic [255:0] d,
                     input logic [1:0] r, input logic l);
    if (k >= got_q.size()) begin
      check($sformatf("%s_count", nm), got_q.size(), k + 1);
      return;
    end
    check($sformatf("%s_b%0d_data", nm, k), got_q[k].data, d);
    check($sformatf("%s_b%0d_resp", nm, k), got_q[k].resp, r);
    check($sformatf("%s_b%0d_last", nm, k), got_q[k].last, l);
  endtask

  initial begin
    logic [1:0] werr;
    int t;
    axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0;
    axi.arburst = '0; axi.arvalid = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 i_reset = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 16; i++) preload(i, fill(8'((i + 1) * 17)));

    // single beat, latency and literal pin
    preload(0, {128'h0, 128'hDEADBEEF_CAFEBABE_12345678_ABCDEF01});
    run(7'h05, 32'h0, 8'd0, 3'd5, 2'b01);
    check("t1_count", got_q.size(), 1);
    if (got_q.size() == 1) begin
      check("t1_data", got_q[0].data[127:0], 128'hDEADBEEF_CAFEBABE_12345678_ABCDEF01);
      check("t1_last", got_q[0].last, 1);
      check("t1_resp", got_q[0].resp, 0);
      check("t1_id", got_q[0].id, 7'h05);
      check("t1_latency", got_q[0].cyc - ar_cyc, 1);
    end
    preload(0, fill(8'h11));

    // unaligned INCR, continuous rready
    run(7'h12, 32'h10, 8'd3, 3'd5, 2'b01);
    for (int k = 0; k < 4; k++) lit("t2", k, fill(8'((k + 1) * 17)), 2'b00, k == 3);
    if (got_q.size() == 4)
      for (int k = 0; k < 3; k++) check("t2_consec", got_q[k + 1].cyc - got_q[k].cyc, 1);

    // same burst with stalls
    rr_ph = 0; rr_mode = 1;
    run(7'h13, 32'h10, 8'd3, 3'd5, 2'b01);
    for (int k = 0; k < 4; k++) lit("t3", k, fill(8'((k + 1) * 17)), 2'b00, k == 3);
    rr_mode = 0;

    // WRAP 0x40 len3 -> idx 2,3,0,1
    run(7'h21, 32'h40, 8'd3, 3'd5, 2'b10);
    lit("t4", 0, fill(8'h33), 2'b00, 1'b0);
    lit("t4", 1, fill(8'h44), 2'b00, 1'b0);
    lit("t4", 2, fill(8'h11), 2'b00, 1'b0);
    lit("t4", 3, fill(8'h22), 2'b00, 1'b1);

    // out of range
    run(7'h22, 32'h200, 8'd1, 3'd5, 2'b01);
    lit("t5", 0, '0, 2'b11, 1'b0);
    lit("t5", 1, '0, 2'b11, 1'b1);

    // illegal WRAP length
`ifdef AXI_RD_ERR_CHECK_EN
    werr = 2'b10;
`else
    werr = 2'b00;
`endif
    run(7'h23, 32'h0, 8'd2, 3'd5, 2'b10);
    lit("t6", 0, fill(8'h11), werr, 1'b0);
    lit("t6", 1, fill(8'h22), werr, 1'b0);
    lit("t6", 2, fill(8'h33), werr, 1'b1);

    // oversize arsize
    run(7'h24, 32'h0, 8'd1, 3'd7, 2'b01);
    lit("t11", 0, fill(8'h11), werr == 2'b10 ? 2'b10 : 2'b00, 1'b0);
    lit("t11", 1, fill(8'h22), werr == 2'b10 ? 2'b10 : 2'b00, 1'b1);

    // FIXED, reserved burst, 32-bit wrap, narrow INCR
    run(7'h25, 32'h60, 8'd2, 3'd5, 2'b00);
    for (int k = 0; k < 3; k++) lit("t8", k, fill(8'h44), 2'b00, k == 2);
    run(7'h26, 32'h20, 8'd1, 3'd5, 2'b11);
    lit("t10", 0, fill(8'h22), 2'b00, 1'b0);
    lit("t10", 1, fill(8'h33), 2'b00, 1'b1);
    run(7'h27, 32'hFFFF_FFE0, 8'd1, 3'd5, 2'b01);
    lit("t9", 0, '0, 2'b11, 1'b0);
    lit("t9", 1, fill(8'h11), 2'b00, 1'b1);
    run(7'h28, 32'h1C, 8'd2, 3'd2, 2'b01);
    lit("t12", 0, fill(8'h11), 2'b00, 1'b0);
    lit("t12", 1, fill(8'h22), 2'b00, 1'b0);
    lit("t12", 2, fill(8'h22), 2'b00, 1'b1);

    // preload colliding with beat load returns the old word
    got_q.delete();
    @(posedge i_clk); #1;
    axi.arid = 7'h30; axi.araddr = 32'h0; axi.arlen = 8'd0; axi.arsize = 3'd5;
    axi.arburst = 2'b01; axi.arvalid = 1'b1;
    i_wr_en = 1'b1; i_wr_idx = 4'd0; i_wr_data = fill(8'hA5);
    @(negedge i_clk); #1;
    check("t13_arready", axi.arready, 1);
    @(posedge i_clk);
    mdl_mem[0] = fill(8'hA5);
    #1 axi.arvalid = 1'b0; i_wr_en = 1'b0;
    wait_drain();
    lit("t13_old", 0, fill(8'h11), 2'b00, 1'b1);
    run(7'h31, 32'h0, 8'd0, 3'd5, 2'b01);
    lit("t13_new", 0, fill(8'hA5), 2'b00, 1'b1);

    // reset after beat 1 of a len3 burst
    got_q.delete();
    do_ar(7'h40, 32'h0, 8'd3, 3'd5, 2'b01);
    t = 0;
    while (got_q.size() < 2 && t < 50) begin
      @(negedge i_clk); #1;
      t++;
    end
    check("t7_beats_before_reset", got_q.size(), 2);
    @(posedge i_clk); #1 i_reset = 1'b1;
    @(posedge i_clk); #1 i_reset = 1'b0;
    @(negedge i_clk); #1;
    check("t7_rvalid_after_reset", axi.rvalid, 0);
    check("t7_arready_after_reset", axi.arready, 0);
    @(negedge i_clk); #1;
    check("t7_arready_next", axi.arready, 1);
    run(7'h41, 32'hA0, 8'd0, 3'd5, 2'b01);
    lit("t7_post", 0, fill(8'h66), 2'b00, 1'b1);
    if (got_q.size() == 1) check("t7_post_id", got_q[0].id, 7'h41);

    repeat (3) @(posedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
